// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and encodings for the multicycle MIPS control
//               unit: FSM state codes, opcodes, funct codes and datapath
//               select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

  // Main FSM state codes; 15 is never entered
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    ORIEX   = 4'd12,
    ORIWB   = 4'd13,
    BNEEX   = 4'd14
  } statetype;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU B operand select
  localparam logic [2:0] ALUSRCB_B       = 3'b000;
  localparam logic [2:0] ALUSRCB_FOUR    = 3'b001;
  localparam logic [2:0] ALUSRCB_SIMM    = 3'b010;
  localparam logic [2:0] ALUSRCB_SIMM_SH = 3'b011;
  localparam logic [2:0] ALUSRCB_ZIMM    = 3'b100;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operation class handed from FSM to ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/mc_aludec.sv
`default_nettype none
// ============================================================================
// Module      : mc_aludec
// Description : ALU decoder. Maps the FSM's aluop class, and for R-type the
//               funct field, onto the 3-bit ALU control code.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Decode ALU operation; unknown funct falls back to add
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_OR:  alucontrol = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule : mc_aludec
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Control unit of the multicycle MIPS core. Moore main FSM that
//               sequences the shared datapath, plus the ALU decoder.
//               Optional feature macro: MC_BNE_EN (adds the bne instruction).
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [2:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic [STATE_W-1:0] state
);

  statetype   state_q;
  statetype   state_d;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       regwrite_raw;
`ifdef MC_BNE_EN
  logic       bne;
`endif

  // State register; reset parks the machine in FETCH immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d      = FETCH;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = ALUOP_ADD;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = ALUSRCB_B;
    pcsrc        = PCSRC_ALU;
`ifdef MC_BNE_EN
    bne          = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = ALUSRCB_FOUR;
        state_d     = DECODE;
      end
      DECODE: begin
        alusrcb = ALUSRCB_SIMM_SH;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          OP_ORI:       state_d = ORIEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          // Unsupported opcodes are dropped without side effects
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_SIMM;
        // IR still holds the instruction, so op tells lw from sw here
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        branch  = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_SIMM;
        state_d = ADDIWB;
      end
      ADDIWB: regwrite_raw = 1'b1;
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = PCSRC_JUMP;
      end
      ORIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_ZIMM;
        aluop   = ALUOP_OR;
        state_d = ORIWB;
      end
      ORIWB: regwrite_raw = 1'b1;
`ifdef MC_BNE_EN
      BNEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        bne     = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // Write strobes are suppressed while reset is held so nothing commits
  always_comb begin
`ifdef MC_BNE_EN
    pcen   = reset & (pcwrite | (branch & zero) | (bne & ~zero));
`else
    pcen   = reset & (pcwrite | (branch & zero));
`endif
    memwrite = reset & memwrite_raw;
    irwrite  = reset & irwrite_raw;
    regwrite = reset & regwrite_raw;
  end

  assign state = STATE_W'(state_q);

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule : mc_controller
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Directed self-checking bench for mc_controller. Walks each
//               instruction class through its state sequence and checks the
//               key control outputs against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [2:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mc_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state      (state)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Held in reset: FETCH with strobes forced low, then release
  task automatic test_reset();
    op = 6'b100011; funct = 6'd0; zero = 1'b0;
    #10;
    checks++; if (state !== 4'd0)      begin errors++; $display("FAIL reset state: got %0d expected 0", state); end
    checks++; if (pcen !== 1'b0)       begin errors++; $display("FAIL reset pcen: got %b expected 0", pcen); end
    checks++; if (irwrite !== 1'b0)    begin errors++; $display("FAIL reset irwrite: got %b expected 0", irwrite); end
    checks++; if (regwrite !== 1'b0)   begin errors++; $display("FAIL reset regwrite: got %b expected 0", regwrite); end
    checks++; if (memwrite !== 1'b0)   begin errors++; $display("FAIL reset memwrite: got %b expected 0", memwrite); end
    checks++; if (alusrcb !== 3'b001)  begin errors++; $display("FAIL reset alusrcb: got %b expected 001", alusrcb); end
    checks++; if (alucontrol !== 3'b010) begin errors++; $display("FAIL reset alucontrol: got %b expected 010", alucontrol); end
    #12;
    reset = 1'b1;
    #1;
    checks++; if (state !== 4'd0)      begin errors++; $display("FAIL release state: got %0d expected 0", state); end
    checks++; if (irwrite !== 1'b1)    begin errors++; $display("FAIL release irwrite: got %b expected 1", irwrite); end
    checks++; if (pcen !== 1'b1)       begin errors++; $display("FAIL release pcen: got %b expected 1", pcen); end
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL lw state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
      checks++; if (irwrite !== (exp_s[i] == 4'd0)) begin errors++; $display("FAIL lw irwrite[%0d]: got %b", i, irwrite); end
      checks++; if (pcen !== (exp_s[i] == 4'd0)) begin errors++; $display("FAIL lw pcen[%0d]: got %b", i, pcen); end
      checks++; if (regwrite !== (exp_s[i] == 4'd4)) begin errors++; $display("FAIL lw regwrite[%0d]: got %b", i, regwrite); end
      checks++; if (memtoreg !== (exp_s[i] == 4'd4)) begin errors++; $display("FAIL lw memtoreg[%0d]: got %b", i, memtoreg); end
      checks++; if (iord !== (exp_s[i] == 4'd3)) begin errors++; $display("FAIL lw iord[%0d]: got %b", i, iord); end
      if (i < 5) step();
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL sw state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
      checks++; if (memwrite !== (exp_s[i] == 4'd5)) begin errors++; $display("FAIL sw memwrite[%0d]: got %b", i, memwrite); end
      checks++; if (iord !== (exp_s[i] == 4'd5)) begin errors++; $display("FAIL sw iord[%0d]: got %b", i, iord); end
      if (exp_s[i] == 4'd2) begin
        checks++; if (alusrcb !== 3'b010) begin errors++; $display("FAIL sw memadr alusrcb: got %b expected 010", alusrcb); end
      end
      if (i < 4) step();
    end
  endtask

  // R-type with several funct codes; alucontrol checked in RTYPEEX
  task automatic test_rtype();
    logic [5:0] fn  [6] = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b111111};
    logic [2:0] alu [6] = '{3'b111,    3'b010,    3'b110,    3'b000,    3'b001,    3'b010};
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    op = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      funct = fn[k];
      for (int i = 0; i < 5; i++) begin
        checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL rtype state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
        if (exp_s[i] == 4'd6) begin
          checks++; if (alucontrol !== alu[k]) begin errors++; $display("FAIL rtype alucontrol funct=%b: got %b expected %b", fn[k], alucontrol, alu[k]); end
          checks++; if (alusrca !== 1'b1) begin errors++; $display("FAIL rtype alusrca: got %b expected 1", alusrca); end
        end
        checks++; if (regdst !== (exp_s[i] == 4'd7)) begin errors++; $display("FAIL rtype regdst[%0d]: got %b", i, regdst); end
        checks++; if (regwrite !== (exp_s[i] == 4'd7)) begin errors++; $display("FAIL rtype regwrite[%0d]: got %b", i, regwrite); end
        if (i < 4) step();
      end
    end
  endtask

  task automatic test_beq();
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    op = 6'b000100;
    for (int z = 1; z >= 0; z--) begin
      zero = 1'(z);
      for (int i = 0; i < 4; i++) begin
        checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL beq state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
        if (exp_s[i] == 4'd8) begin
          checks++; if (pcen !== 1'(z)) begin errors++; $display("FAIL beq pcen zero=%0d: got %b expected %0d", z, pcen, z); end
          checks++; if (pcsrc !== 2'b01) begin errors++; $display("FAIL beq pcsrc: got %b expected 01", pcsrc); end
          checks++; if (alucontrol !== 3'b110) begin errors++; $display("FAIL beq alucontrol: got %b expected 110", alucontrol); end
        end
        if (i < 3) step();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_ori();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd12, 4'd13, 4'd0};
    op = 6'b001101;
    for (int i = 0; i < 5; i++) begin
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL ori state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
      if (exp_s[i] == 4'd12) begin
        checks++; if (alusrcb !== 3'b100) begin errors++; $display("FAIL ori alusrcb: got %b expected 100", alusrcb); end
        checks++; if (alucontrol !== 3'b001) begin errors++; $display("FAIL ori alucontrol: got %b expected 001", alucontrol); end
      end
      checks++; if (regwrite !== (exp_s[i] == 4'd13)) begin errors++; $display("FAIL ori regwrite[%0d]: got %b", i, regwrite); end
      if (i < 4) step();
    end
  endtask

  task automatic test_jump();
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd11, 4'd0};
    op = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL j state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
      if (exp_s[i] == 4'd11) begin
        checks++; if (pcen !== 1'b1) begin errors++; $display("FAIL j pcen: got %b expected 1", pcen); end
        checks++; if (pcsrc !== 2'b10) begin errors++; $display("FAIL j pcsrc: got %b expected 10", pcsrc); end
      end
      if (i < 3) step();
    end
  endtask

  // Unsupported opcode returns to FETCH with no write strobes
  task automatic test_illegal(input logic [5:0] bad_op);
    logic [3:0] exp_s [3] = '{4'd0, 4'd1, 4'd0};
    op = bad_op;
    for (int i = 0; i < 3; i++) begin
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL illegal op=%b state[%0d]: got %0d expected %0d", bad_op, i, state, exp_s[i]); end
      checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL illegal regwrite[%0d]: got %b expected 0", i, regwrite); end
      checks++; if (memwrite !== 1'b0) begin errors++; $display("FAIL illegal memwrite[%0d]: got %b expected 0", i, memwrite); end
      if (i < 2) step();
    end
  endtask

  // Abort a lw in MEMRD; state drops to FETCH at once and no writeback occurs
  task automatic test_reset_mid();
    op = 6'b100011;
    step(); step(); step();
    checks++; if (state !== 4'd3) begin errors++; $display("FAIL midreset pre state: got %0d expected 3", state); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL midreset state: got %0d expected 0", state); end
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL midreset regwrite: got %b expected 0", regwrite); end
    step();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL midreset held state: got %0d expected 0", state); end
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL midreset held regwrite: got %b expected 0", regwrite); end
    op = 6'b111111;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (irwrite !== 1'b1) begin errors++; $display("FAIL midreset release irwrite: got %b expected 1", irwrite); end
    test_illegal(6'b111111);
  endtask

`ifdef MC_BNE_EN
  task automatic test_bne();
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd14, 4'd0};
    op = 6'b000101;
    for (int z = 0; z < 2; z++) begin
      zero = 1'(z);
      for (int i = 0; i < 4; i++) begin
        checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL bne state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
        if (exp_s[i] == 4'd14) begin
          checks++; if (pcen !== 1'(1 - z)) begin errors++; $display("FAIL bne pcen zero=%0d: got %b expected %0d", z, pcen, 1 - z); end
          checks++; if (alucontrol !== 3'b110) begin errors++; $display("FAIL bne alucontrol: got %b expected 110", alucontrol); end
        end
        if (i < 3) step();
      end
    end
    zero = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    op    = 6'd0;
    funct = 6'd0;
    zero  = 1'b0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_ori();
    test_jump();
    test_illegal(6'b111111);
`ifdef MC_BNE_EN
    test_bne();
`else
    test_illegal(6'b000101);
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mc_controller
`default_nettype wire
